// File: rtl/kbd_event_queue_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | kbd_pkg                                                            |
// | Shared types and constants for the keyboard event queue: decoder   |
// | states, set-2 prefix/ack bytes, modifier key codes and the bit     |
// | layout of the event word.                                          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package kbd_pkg;

  // Decoder states: which prefix bytes have been seen for the pending key
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_SKIP    = 3'd4
  } kbd_state_e;

  // Prefix bytes
  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_F0 = 8'hF0;
  localparam logic [7:0] CODE_E1 = 8'hE1;

  // Controller/ack bytes that never describe a key
  localparam logic [7:0] CODE_00 = 8'h00;
  localparam logic [7:0] CODE_AA = 8'hAA;
  localparam logic [7:0] CODE_EE = 8'hEE;
  localparam logic [7:0] CODE_FA = 8'hFA;
  localparam logic [7:0] CODE_FE = 8'hFE;
  localparam logic [7:0] CODE_FF = 8'hFF;

  // Modifier key codes
  localparam logic [7:0] MOD_LSHIFT = 8'h12;
  localparam logic [7:0] MOD_RSHIFT = 8'h59;
  localparam logic [7:0] MOD_CTRL   = 8'h14;
  localparam logic [7:0] MOD_CAPS   = 8'h58;

  // Pause sends E1 followed by seven more bytes that carry no key action
  localparam int         SKIP_W     = 3;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // Event word field positions
  localparam int EV_BRK_BIT   = 15;
  localparam int EV_EXT_BIT   = 14;
  localparam int EV_SHIFT_BIT = 11;
  localparam int EV_CTRL_BIT  = 10;
  localparam int EV_CAPS_BIT  = 9;
  localparam int EV_CODE_LSB  = 0;

  // True for bytes the keyboard sends as status/acknowledge, not as keys
  function automatic logic is_ack_code(input logic [7:0] code);
    return (code == CODE_00) || (code == CODE_AA) || (code == CODE_EE) ||
           (code == CODE_FA) || (code == CODE_FE) || (code == CODE_FF);
  endfunction

endpackage
`default_nettype wire

// File: rtl/kbd_event_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | kbd_event_queue_if                                                 |
// | Byte-side (ps2_kbd) and event-side (cpu) signals of the keyboard   |
// | event queue. master = environment, slave = the queue.              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface kbd_event_queue_if #(
  parameter int CODE_W     = 8,
  parameter int EV_W       = 16,
  parameter int FIFO_DEPTH = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [CODE_W-1:0] ps2_data;
  logic              ps2_ready;
  logic              ps2_rdn;
  logic              ev_rd;
  logic [EV_W-1:0]   ev_rdata;
  logic              ev_ready;
  logic [CNT_W-1:0]  ev_count;

  modport master (
    output ps2_data, ps2_ready, ev_rd,
    input  ps2_rdn, ev_rdata, ev_ready, ev_count
  );

  modport slave (
    input  ps2_data, ps2_ready, ev_rd,
    output ps2_rdn, ev_rdata, ev_ready, ev_count
  );

endinterface
`default_nettype wire

// File: rtl/kbd_event_queue_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | kbd_event_fifo                                                     |
// | Synchronous FIFO for event words. Head is presented combinationally|
// | and reads as zero when empty; pops of an empty queue and pushes of |
// | a full queue are ignored.                                          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module kbd_event_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       clrn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occupancy;
  logic             do_push;
  logic             do_pop;

  assign full     = (occupancy == CNT_W'(DEPTH));
  assign empty    = (occupancy == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign count    = occupancy;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are qualified by occupancy so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!clrn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/kbd_event_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | kbd_event_queue                                                    |
// | Pops set-2 scan bytes from ps2_kbd, folds E0/F0/E1 prefixes into   |
// | one event word per key action, tracks shift/ctrl/caps and queues   |
// | events for the cpu.                                                |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module kbd_event_queue
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CODE_W     = 8,
  parameter int EV_W       = 16
) (
  input  logic             clk,
  input  logic             clrn,
  kbd_event_queue_if.slave bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  kbd_state_e        state;
  kbd_state_e        state_next;
  logic [SKIP_W-1:0] skip_cnt;
  logic [SKIP_W-1:0] skip_next;

  logic              consume;
  logic              scan_valid;
  logic [CODE_W-1:0] scan_byte;

  logic              key_fire;
  logic              key_brk;
  logic              key_ext;

  logic              shift;
  logic              ctrl;
  logic              caps;
  logic              caps_held;
  logic              shift_next;
  logic              ctrl_next;
  logic              caps_next;
  logic              caps_held_next;

  logic [EV_W-1:0]   event_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  // scan_valid doubles as the settle gap after each pop, and fifo_full is
  // taken from the registered occupancy, so a byte is only taken when its
  // event is guaranteed a slot.
  assign consume     = clrn && bus.ps2_ready && !fifo_full && !scan_valid;
  assign bus.ps2_rdn = !consume;

  // Capture the popped byte; it is decoded in the following cycle
  always_ff @(posedge clk) begin
    if (!clrn) begin
      scan_valid <= 1'b0;
      scan_byte  <= '0;
    end else begin
      scan_valid <= consume;
      if (consume) begin
        scan_byte <= bus.ps2_data;
      end
    end
  end

  // Decoder state, pause skip counter and modifier registers
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state     <= ST_IDLE;
      skip_cnt  <= '0;
      shift     <= 1'b0;
      ctrl      <= 1'b0;
      caps      <= 1'b0;
      caps_held <= 1'b0;
    end else begin
      state     <= state_next;
      skip_cnt  <= skip_next;
      shift     <= shift_next;
      ctrl      <= ctrl_next;
      caps      <= caps_next;
      caps_held <= caps_held_next;
    end
  end

  // Prefix decoder: decides whether this byte completes a key action
  always_comb begin
    state_next = state;
    skip_next  = skip_cnt;
    key_fire   = 1'b0;
    key_brk    = 1'b0;
    key_ext    = 1'b0;
    if (scan_valid) begin
      case (state)
        ST_IDLE: begin
          if (scan_byte == CODE_E0) begin
            state_next = ST_EXT;
          end else if (scan_byte == CODE_F0) begin
            state_next = ST_BRK;
          end else if (scan_byte == CODE_E1) begin
            state_next = ST_SKIP;
            skip_next  = PAUSE_SKIP;
          end else if (!is_ack_code(scan_byte)) begin
            key_fire = 1'b1;
          end
        end
        ST_EXT: begin
          if (scan_byte == CODE_F0) begin
            state_next = ST_EXT_BRK;
          end else begin
            key_fire   = 1'b1;
            key_ext    = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          key_fire   = 1'b1;
          key_brk    = 1'b1;
          state_next = ST_IDLE;
        end
        ST_EXT_BRK: begin
          key_fire   = 1'b1;
          key_brk    = 1'b1;
          key_ext    = 1'b1;
          state_next = ST_IDLE;
        end
        ST_SKIP: begin
          skip_next = skip_cnt - SKIP_W'(1);
          if (skip_cnt <= SKIP_W'(1)) begin
            state_next = ST_IDLE;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Modifier update and event word; the event reports the post-update state.
  // Caps lock only toggles on the first make of a hold, so typematic repeats
  // leave it alone. E0 58 is not the caps key, hence the non-extended filter.
  always_comb begin
    shift_next     = shift;
    ctrl_next      = ctrl;
    caps_next      = caps;
    caps_held_next = caps_held;
    if (key_fire) begin
      if (!key_ext && (scan_byte == MOD_LSHIFT || scan_byte == MOD_RSHIFT)) begin
        shift_next = !key_brk;
      end
      if (scan_byte == MOD_CTRL) begin
        ctrl_next = !key_brk;
      end
      if (!key_ext && scan_byte == MOD_CAPS) begin
        if (key_brk) begin
          caps_held_next = 1'b0;
        end else begin
          if (!caps_held) begin
            caps_next = !caps;
          end
          caps_held_next = 1'b1;
        end
      end
    end
    event_word                           = '0;
    event_word[EV_BRK_BIT]               = key_brk;
    event_word[EV_EXT_BIT]               = key_ext;
    event_word[EV_SHIFT_BIT]             = shift_next;
    event_word[EV_CTRL_BIT]              = ctrl_next;
    event_word[EV_CAPS_BIT]              = caps_next;
    event_word[EV_CODE_LSB +: CODE_W]    = scan_byte;
  end

  kbd_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clrn      (clrn),
    .push      (key_fire),
    .push_data (event_word),
    .pop       (bus.ev_rd),
    .pop_data  (bus.ev_rdata),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.ev_ready = !fifo_empty;
  assign bus.ev_count = fifo_count;

endmodule
`default_nettype wire

// File: tb/tb_kbd_event_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_kbd_event_queue                                                 |
// | Self-checking bench: spec vectors, multi-cycle corner sequences    |
// | and random byte streams against a behavioural event model.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_kbd_event_queue;
  localparam int DEPTH = 8;

  logic clk;
  logic clrn;
  int   errors = 0;
  int   checks = 0;

  kbd_event_queue_if #(.CODE_W(8), .EV_W(16), .FIFO_DEPTH(DEPTH)) bus ();

  kbd_event_queue #(.FIFO_DEPTH(DEPTH), .CODE_W(8), .EV_W(16)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ps2_kbd byte source and reference model state
  logic [7:0]  src_q [$];
  logic [15:0] exp_q [$];
  logic [15:0] m_pend;
  bit          m_pend_v, m_gap, last_cons;
  bit          m_ext, m_brk, m_shift, m_ctrl, m_caps, m_held;
  int          m_skip;

  typedef struct {
    logic [7:0]  b [10];
    int          nb;
    logic [15:0] e [4];
    int          ne;
  } vec_t;
  vec_t vt [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pend_v = 0; m_pend = '0; m_gap = 0;
    m_ext = 0; m_brk = 0; m_skip = 0;
    m_shift = 0; m_ctrl = 0; m_caps = 0; m_held = 0;
  endtask

  // Key-action semantics of the set-2 byte stream
  task automatic model_byte(input logic [7:0] b, output bit has_ev, output logic [15:0] ev);
    bit brk, ext;
    has_ev = 0; ev = '0;
    if (m_skip > 0) begin m_skip--; return; end
    if (!m_ext && !m_brk && b == 8'hE1) begin m_skip = 7; return; end
    if (!m_ext && !m_brk && b == 8'hE0) begin m_ext = 1; return; end
    if (!m_brk && b == 8'hF0) begin m_brk = 1; return; end
    if (!m_ext && !m_brk && (b == 8'h00 || b == 8'hAA || b == 8'hEE ||
                             b == 8'hFA || b == 8'hFE || b == 8'hFF)) return;
    brk = m_brk; ext = m_ext;
    m_brk = 0; m_ext = 0;
    if (!ext && (b == 8'h12 || b == 8'h59)) m_shift = !brk;
    if (b == 8'h14) m_ctrl = !brk;
    if (!ext && b == 8'h58) begin
      if (brk) m_held = 0;
      else begin
        if (!m_held) m_caps = !m_caps;
        m_held = 1;
      end
    end
    has_ev = 1;
    ev = {brk, ext, 2'b00, m_shift, m_ctrl, m_caps, 1'b0, b};
  endtask

  // One clock: drive, check against the model, advance source and model
  task automatic step(input bit rd);
    bit          cons, has;
    logic [15:0] ev;
    bus.ps2_ready = (src_q.size() != 0);
    bus.ps2_data  = (src_q.size() != 0) ? src_q[0] : 8'h00;
    bus.ev_rd     = rd;
    #1;
    chk("ev_ready", bus.ev_ready, exp_q.size() != 0);
    chk("ev_count", bus.ev_count, exp_q.size());
    chk("ev_rdata", bus.ev_rdata, (exp_q.size() != 0) ? exp_q[0] : 16'h0);
    chk("ps2_rdn", bus.ps2_rdn,
        !(clrn && bus.ps2_ready && (exp_q.size() < DEPTH) && !m_gap));
    cons = !bus.ps2_rdn && (src_q.size() != 0);
    @(posedge clk);
    if (!clrn) model_reset();
    else begin
      if (rd && exp_q.size() != 0) void'(exp_q.pop_front());
      if (m_pend_v) begin exp_q.push_back(m_pend); m_pend_v = 0; end
      m_gap = cons;
      if (cons) begin
        model_byte(src_q[0], has, ev);
        m_pend_v = has; m_pend = ev;
      end
    end
    if (cons) void'(src_q.pop_front());
    last_cons = cons;
    @(negedge clk);
    bus.ev_rd = 1'b0;
  endtask

  task automatic settle(input int budget);
    int n = 0;
    while ((src_q.size() != 0 || m_pend_v) && n < budget) begin
      step(0);
      n++;
    end
    chk("settle_timeout", n >= budget, 0);
  endtask

  task automatic do_reset();
    src_q.delete();
    clrn = 1'b0;
    step(0);
    clrn = 1'b1;
  endtask

  logic [7:0] bp_codes [9];
  logic [7:0] pool [12];

  initial begin
    vt[0] = '{b: '{8'h1C,8'hF0,8'h1C,0,0,0,0,0,0,0}, nb: 3,
              e: '{16'h001C,16'h801C,0,0}, ne: 2};
    vt[1] = '{b: '{8'hE0,8'h75,8'hE0,8'hF0,8'h75,0,0,0,0,0}, nb: 5,
              e: '{16'h4075,16'hC075,0,0}, ne: 2};
    vt[2] = '{b: '{8'hE0,8'h14,8'hE0,8'hF0,8'h14,0,0,0,0,0}, nb: 5,
              e: '{16'h4414,16'hC014,0,0}, ne: 2};
    vt[3] = '{b: '{8'h12,8'h1C,8'hF0,8'h12,8'h1C,0,0,0,0,0}, nb: 5,
              e: '{16'h0812,16'h081C,16'h8012,16'h001C}, ne: 4};
    vt[4] = '{b: '{8'h58,8'h58,8'hF0,8'h58,8'h58,0,0,0,0,0}, nb: 5,
              e: '{16'h0258,16'h0258,16'h8258,16'h0058}, ne: 4};
    vt[5] = '{b: '{8'hE1,8'h14,8'h77,8'hE1,8'hF0,8'h14,8'hF0,8'h77,8'h1C,0}, nb: 9,
              e: '{16'h001C,0,0,0}, ne: 1};
    vt[6] = '{b: '{8'hFA,8'hAA,8'h1C,8'hEE,8'hFE,8'hFF,8'h00,0,0,0}, nb: 7,
              e: '{16'h001C,0,0,0}, ne: 1};
    vt[7] = '{b: '{8'h59,8'hF0,8'h59,0,0,0,0,0,0,0}, nb: 3,
              e: '{16'h0859,16'h8059,0,0}, ne: 2};
    vt[8] = '{b: '{8'hE0,8'h12,0,0,0,0,0,0,0,0}, nb: 2,
              e: '{16'h4012,0,0,0}, ne: 1};
    bp_codes = '{8'h15,8'h1D,8'h24,8'h2D,8'h2C,8'h35,8'h3C,8'h43,8'h44};
    pool = '{8'h12,8'h59,8'h14,8'h58,8'hE0,8'hF0,8'hE1,8'hFA,8'hAA,8'h1C,8'h75,8'h00};

    bus.ps2_ready = 1'b0; bus.ps2_data = 8'h00; bus.ev_rd = 1'b0;
    clrn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    chk("rst_ready", bus.ev_ready, 0);
    chk("rst_count", bus.ev_count, 0);
    chk("rst_rdata", bus.ev_rdata, 0);
    chk("rst_rdn", bus.ps2_rdn, 1);

    // Spec vectors
    for (int i = 0; i < 9; i++) begin
      do_reset();
      for (int j = 0; j < vt[i].nb; j++) src_q.push_back(vt[i].b[j]);
      settle(100);
      chk($sformatf("vec%0d_count", i), bus.ev_count, vt[i].ne);
      for (int j = 0; j < vt[i].ne; j++) begin
        chk($sformatf("vec%0d_ev%0d", i, j), bus.ev_rdata, vt[i].e[j]);
        step(1);
      end
      chk($sformatf("vec%0d_empty", i), bus.ev_ready, 0);
    end

    // Latency: rdn low in T, ev_ready high in T+2
    do_reset();
    src_q.push_back(8'h1C);
    step(0);
    chk("lat_consumed", last_cons, 1);
    chk("lat_ready_t1", bus.ev_ready, 0);
    step(0);
    chk("lat_ready_t2", bus.ev_ready, 1);
    chk("lat_rdata", bus.ev_rdata, 16'h001C);

    // Pop of an empty queue leaves the pointers alone
    step(1);
    step(1);
    src_q.push_back(8'h1D);
    settle(20);
    chk("empty_rd_count", bus.ev_count, 1);
    chk("empty_rd_rdata", bus.ev_rdata, 16'h001D);

    // Backpressure with nine makes and no reads
    do_reset();
    for (int i = 0; i < 9; i++) src_q.push_back(bp_codes[i]);
    repeat (40) step(0);
    chk("bp_count", bus.ev_count, 8);
    chk("bp_ready_in", bus.ps2_ready, 1);
    chk("bp_rdn_held", bus.ps2_rdn, 1);
    chk("bp_first", bus.ev_rdata, {8'h00, bp_codes[0]});
    step(1);
    settle(20);
    chk("bp_count_refill", bus.ev_count, 8);
    for (int i = 1; i < 9; i++) begin
      chk($sformatf("bp_order%0d", i), bus.ev_rdata, {8'h00, bp_codes[i]});
      step(1);
    end

    // Reset after a break prefix discards it
    do_reset();
    src_q.push_back(8'hF0);
    step(0);
    clrn = 1'b0;
    step(0);
    clrn = 1'b1;
    chk("rst2_ready", bus.ev_ready, 0);
    chk("rst2_count", bus.ev_count, 0);
    chk("rst2_rdata", bus.ev_rdata, 0);
    chk("rst2_rdn", bus.ps2_rdn, 1);
    src_q.push_back(8'h1C);
    settle(20);
    chk("rst2_event", bus.ev_rdata, 16'h001C);

    // Random byte streams, random reads, occasional reset
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      int r;
      if (src_q.size() < 4 && $urandom_range(0, 1) == 1) begin
        r = $urandom_range(0, 15);
        src_q.push_back(r < 12 ? pool[r] : 8'($urandom));
      end
      if ($urandom_range(0, 399) == 0) clrn = 1'b0;
      step($urandom_range(0, 2) == 0);
      clrn = 1'b1;
    end
    settle(200);
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) step(1);
    chk("rand_drained", bus.ev_ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
